key_scan_165: RTL and testbench
===============================

KEY_SCAN_165 -- requirements
Module: key_scan_165

Interface
REQ-001 Parameter CLK_DIV, default 300, meaning: system clocks per scan tick (12 MHz / 300 = 40 kHz); legal range >= 2.
REQ-002 Parameter NBITS, default 16, meaning: total bits in the cascaded 74HC165 chain; legal range 8..32.
REQ-003 Parameter DEBOUNCE, default 4, meaning: number of consecutive identical frames required before keys updates; legal range 1..15.
REQ-004 clk  input  1  system clock, 12 MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 q7  input  1  serial data from Q7 of the last 74HC165 in the chain.
REQ-007 pl  output  1  74HC165 parallel load, active-low.
REQ-008 cp  output  1  74HC165 shift clock; the chain shifts on the rising edge.
REQ-009 raw  output  NBITS  last captured frame, 0 = input pulled low (key pressed).
REQ-010 frame_valid  output  1  one-clk pulse when raw updates.
REQ-011 keys  output  NBITS  debounced key state, 1 = pressed (inverse of raw).
REQ-012 key_press  output  NBITS  one-clk pulse per bit on 0->1 transition of keys.

Function
REQ-013 Tick counter shall count 0..CLK_DIV-1 and wrap; tick shall be high for one clk when the count equals CLK_DIV-1; the FSM shall advance only on tick.
REQ-014 FSM states: IDLE -> LOAD -> LATCH -> SAMPLE <-> CLOCK -> DONE -> IDLE; exactly one transition per tick.
REQ-015 IDLE: pl=1, cp=0, bit index cleared; next state LOAD.
REQ-016 LOAD: pl=0 for exactly one tick period; next state LATCH.
REQ-017 LATCH: pl=1; next state SAMPLE.
REQ-018 SAMPLE: cp=0; shift register <= {shift[NBITS-2:0], q7}, so the first sampled bit lands in raw[NBITS-1] (MSB first); if the bit index equals NBITS-1, next state DONE, else CLOCK.
REQ-019 CLOCK: cp=1, bit index +1; next state SAMPLE.
REQ-020 Per frame: exactly NBITS samples and NBITS-1 cp rising edges; no cp edge follows the last sample.
REQ-021 Frame length shall be 2*NBITS+3 ticks (35 ticks = 10500 clks for default parameters); frames shall repeat back-to-back.
REQ-022 DONE: cp=0, pl=1; raw <= shift register; frame_valid pulses for one clk on the DONE tick.
REQ-023 Debounce: stable counter resets to 1 when the new frame differs from the previous raw, else increments, saturating at DEBOUNCE.
REQ-024 When the stable counter reaches DEBOUNCE, keys shall update to ~raw in the same clk as frame_valid; with DEBOUNCE=1, every frame updates keys.
REQ-025 key_press shall equal keys_new & ~keys_old for one clk on the keys-update cycle, and 0 otherwise; releases shall produce no pulse.
REQ-026 pl and cp shall be registered outputs, glitch-free, and never low and high respectively in the same clk (no cp rising edge while pl=0).

Reset
REQ-027 While rst_n=0: pl=1, cp=0, raw=all ones, keys=0, key_press=0, frame_valid=0; FSM=IDLE; tick counter, bit index and stable counter=0.
REQ-028 Reset asserted mid-frame shall take effect immediately (asynchronous), discard the partial frame, and produce no frame_valid; after release, the first frame starts from IDLE.

Verification (bench models a 74HC165 chain: pl low loads the pattern, q7 = pattern bit NBITS-1 after load, shift on cp rising edge)
REQ-029 Pattern 16'hFFFF after reset -> pl low for exactly 300 clks per frame; 15 cp rising edges per frame; frame_valid every 10500 clks; raw=16'hFFFF; keys=0.
REQ-030 Pattern 16'h7FFE -> raw=16'h7FFE (bit-order check); keys=16'h8001 on the 4th matching frame; key_press=16'h8001 for exactly one clk, then 0.
REQ-031 Pattern 16'hFFFE for 2 frames, then 16'hFFFF -> keys stays 0; key_press never asserted.
REQ-032 keys=16'h0001, then pattern 16'hFFFF for 4 frames -> keys=0 on the 4th frame; key_press stays 0.
REQ-033 rst_n low after the 5th cp rising edge -> pl=1 and cp=0 in the same clk; no frame_valid; after release, the next frame captures the pattern correctly.
REQ-034 DEBOUNCE=1, NBITS=8, pattern 8'hA5 -> raw=8'hA5, keys=8'h5A on the first frame_valid; frame length 19 ticks.

Source files
------------

// File: rtl/key_scan_165.sv
// Scanner for a cascaded 74HC165 key chain: it loads the chain, shifts it in MSB first,
// and debounces the captured frame into a key map with per-key press pulses.
module key_scan_165 #(
    parameter int CLK_DIV  = 300,
    parameter int NBITS    = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q7,
    output logic             pl,
    output logic             cp,
    output logic [NBITS-1:0] raw,
    output logic             frame_valid,
    output logic [NBITS-1:0] keys,
    output logic [NBITS-1:0] key_press
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [3:0]    DEB      = 4'(DEBOUNCE);

    typedef enum logic [2:0] {IDLE, LOAD, LATCH, SAMPLE, CLOCK, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic [NBITS-1:0]  raw_q, raw_d;
    logic [NBITS-1:0]  keys_q, keys_d;
    logic [NBITS-1:0]  kp_q, kp_d;
    logic [3:0]        stable_q, stable_d;
    logic              pl_q, pl_d;
    logic              cp_q, cp_d;
    logic              fv_q, fv_d;
    logic              tick;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        raw_d    = raw_q;
        keys_d   = keys_q;
        kp_d     = '0;
        stable_d = stable_q;
        fv_d     = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    bit_d   = '0;
                    state_d = LOAD;
                end
                LOAD:  state_d = LATCH;
                LATCH: state_d = SAMPLE;
                SAMPLE: begin
                    // Sampled before cp rises, so the chain still presents this bit.
                    shift_d = {shift_q[NBITS-2:0], q7};
                    state_d = (bit_q == BIT_LAST) ? DONE : CLOCK;
                end
                CLOCK: begin
                    bit_d   = bit_q + 1'b1;
                    state_d = SAMPLE;
                end
                DONE: begin
                    raw_d = shift_q;
                    fv_d  = 1'b1;
                    if (shift_q != raw_q)
                        stable_d = 4'd1;
                    else if (stable_q != DEB)
                        stable_d = stable_q + 4'd1;
                    if (stable_d == DEB) begin
                        keys_d = ~shift_q;
                        kp_d   = ~shift_q & ~keys_q;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Strobes follow the registered state, so pl and cp change on the same edge as the FSM.
        pl_d = (state_d != LOAD);
        cp_d = (state_d == CLOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            raw_q    <= '1;
            keys_q   <= '0;
            kp_q     <= '0;
            stable_q <= '0;
            pl_q     <= 1'b1;
            cp_q     <= 1'b0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            raw_q    <= raw_d;
            keys_q   <= keys_d;
            kp_q     <= kp_d;
            stable_q <= stable_d;
            pl_q     <= pl_d;
            cp_q     <= cp_d;
            fv_q     <= fv_d;
        end
    end

    assign pl          = pl_q;
    assign cp          = cp_q;
    assign raw         = raw_q;
    assign frame_valid = fv_q;
    assign keys        = keys_q;
    assign key_press   = kp_q;

endmodule

// File: tb/tb_key_scan_165.sv
// Directed bench for key_scan_165: three instances (fast 16-bit, default timing, 8-bit
// DEBOUNCE=1), each fed by a behavioural 74HC165 chain.
module tb_key_scan_165;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst8_n;

    // fast 16-bit instance
    logic        pl, cp, fv, q7;
    logic [15:0] raw, keys, kp, pat, sr;
    // default-timing instance
    logic        pl3, cp3, fv3, q73;
    logic [15:0] raw3, keys3, kp3, sr3;
    // 8-bit, DEBOUNCE=1 instance
    logic        pl8, cp8, fv8, q78;
    logic [7:0]  raw8, keys8, kp8, sr8;

    key_scan_165 #(.CLK_DIV(4), .NBITS(16), .DEBOUNCE(4)) dut (
        .clk(clk), .rst_n(rst_n), .q7(q7), .pl(pl), .cp(cp), .raw(raw),
        .frame_valid(fv), .keys(keys), .key_press(kp));

    key_scan_165 dut300 (
        .clk(clk), .rst_n(rst_n), .q7(q73), .pl(pl3), .cp(cp3), .raw(raw3),
        .frame_valid(fv3), .keys(keys3), .key_press(kp3));

    key_scan_165 #(.CLK_DIV(4), .NBITS(8), .DEBOUNCE(1)) dut8 (
        .clk(clk), .rst_n(rst8_n), .q7(q78), .pl(pl8), .cp(cp8), .raw(raw8),
        .frame_valid(fv8), .keys(keys8), .key_press(kp8));

    // 74HC165 chains: async parallel load while pl is low, shift toward Q7 on cp rise, DS tied high
    always @(posedge cp or negedge pl)
        if (!pl) sr <= pat; else sr <= {sr[14:0], 1'b1};
    always @(posedge cp3 or negedge pl3)
        if (!pl3) sr3 <= 16'hFFFF; else sr3 <= {sr3[14:0], 1'b1};
    always @(posedge cp8 or negedge pl8)
        if (!pl8) sr8 <= 8'hA5; else sr8 <= {sr8[6:0], 1'b1};
    assign q7  = sr[15];
    assign q73 = sr3[15];
    assign q78 = sr8[7];

    int total = 0, bad = 0;
    int kp_cnt = 0, fv_cnt = 0;
    always @(posedge clk) begin
        if (|kp) kp_cnt <= kp_cnt + 1;
        if (fv)  fv_cnt <= fv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fv(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!fv && n < 1000);
        chk(tag, 32'(fv), 32'd1);
    endtask

    initial begin
        int n, pl_lo, rises, kp0, fv0;
        logic cpp;
        rst_n = 1'b0; rst8_n = 1'b0; pat = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pl", 32'(pl), 32'd1);
        chk("rst_cp", 32'(cp), 32'd0);
        chk("rst_raw", 32'(raw), 32'hFFFF);
        chk("rst_keys", 32'(keys), 32'd0);
        chk("rst_kp", 32'(kp), 32'd0);
        chk("rst_fv", 32'(fv), 32'd0);
        chk("rst_raw8", 32'(raw8), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // default timing: first frame, then one full frame measured fv to fv
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!fv3 && n < 11000);
        chk("fv300_first", 32'(fv3), 32'd1);
        chk("fv300_first_len", 32'(n), 32'd10500);
        n = 0; pl_lo = 0; rises = 0; cpp = cp3;
        do begin
            @(posedge clk); #1; n++;
            if (!pl3) pl_lo++;
            if (cp3 && !cpp) rises++;
            cpp = cp3;
        end while (!fv3 && n < 11000);
        chk("fv300_period", 32'(n), 32'd10500);
        chk("pl300_low", 32'(pl_lo), 32'd300);
        chk("cp300_rises", 32'(rises), 32'd15);
        chk("raw300", 32'(raw3), 32'hFFFF);
        chk("keys300", 32'(keys3), 32'd0);

        // all-released chain
        wait_fv("fv_ffff", n);
        chk("raw_ffff", 32'(raw), 32'hFFFF);
        chk("keys_ffff", 32'(keys), 32'd0);

        // short press: two frames then release, never reaches the debounce count
        kp0 = kp_cnt;
        pat = 16'hFFFE;
        wait_fv("fv_glitch1", n);
        chk("raw_glitch", 32'(raw), 32'hFFFE);
        wait_fv("fv_glitch2", n);
        pat = 16'hFFFF;
        repeat (4) wait_fv("fv_glitch_rel", n);
        chk("keys_glitch", 32'(keys), 32'd0);
        chk("kp_glitch", 32'(kp_cnt - kp0), 32'd0);

        // bit order and debounced press on 4th frame
        kp0 = kp_cnt;
        pat = 16'h7FFE;
        wait_fv("fv_7ffe1", n);
        chk("raw_7ffe", 32'(raw), 32'h7FFE);
        chk("keys_7ffe1", 32'(keys), 32'd0);
        chk("frame_len", 32'(n), 32'd140);
        repeat (2) wait_fv("fv_7ffe", n);
        chk("keys_7ffe3", 32'(keys), 32'd0);
        wait_fv("fv_7ffe4", n);
        chk("keys_7ffe4", 32'(keys), 32'h8001);
        chk("kp_7ffe4", 32'(kp), 32'h8001);
        @(posedge clk); #1;
        chk("kp_after", 32'(kp), 32'd0);
        chk("kp_once", 32'(kp_cnt - kp0), 32'd1);

        // keys=0001, then release: clears on 4th frame with no pulse
        pat = 16'hFFFE;
        repeat (4) wait_fv("fv_fffe", n);
        chk("keys_0001", 32'(keys), 32'h0001);
        kp0 = kp_cnt;
        pat = 16'hFFFF;
        repeat (3) wait_fv("fv_rel", n);
        chk("keys_rel3", 32'(keys), 32'h0001);
        wait_fv("fv_rel4", n);
        chk("keys_rel4", 32'(keys), 32'd0);
        chk("kp_rel", 32'(kp_cnt - kp0), 32'd0);

        // reset after the 5th cp rise of a frame
        pat = 16'h7FFE;
        wait_fv("fv_pre_rst", n);
        n = 0; rises = 0; cpp = cp;
        do begin
            @(posedge clk); #1; n++;
            if (cp && !cpp) rises++;
            cpp = cp;
        end while (rises < 5 && n < 1000);
        chk("cp_rises5", 32'(rises), 32'd5);
        fv0 = fv_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_pl", 32'(pl), 32'd1);
        chk("midrst_cp", 32'(cp), 32'd0);
        chk("midrst_raw", 32'(raw), 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_nofv", 32'(fv_cnt - fv0), 32'd0);
        pat = 16'hA55A;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fv("fv_post_rst", n);
        chk("post_rst_len", 32'(n), 32'd140);
        chk("post_rst_raw", 32'(raw), 32'hA55A);

        // 8-bit chain, DEBOUNCE=1
        rst8_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!fv8 && n < 200);
        chk("fv8_first", 32'(fv8), 32'd1);
        chk("fv8_len", 32'(n), 32'd76);
        chk("raw8", 32'(raw8), 32'hA5);
        chk("keys8", 32'(keys8), 32'h5A);
        chk("kp8", 32'(kp8), 32'h5A);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!fv8 && n < 200);
        chk("fv8_period", 32'(n), 32'd76);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
